pwm_duty_ctrl: RTL and testbench
================================

Name: pwm_duty_ctrl

Overview:
- Control front-end for the 10-step PWM generator, which has increase/decrease duty inputs and a 10% step.
- Synchronises and debounces two raw button inputs, then converts presses into clean, spaced single-cycle step commands for the generator.
- Keeps a shadow copy of the duty level so it never commands a step past the limits.
- Optional auto-ramp mode sweeps the duty up and down by itself.

Parameters:
- DEB_CYCLES, 16: consecutive stable synchronised samples required before the debounced level changes.
- GAP_CYCLES, 4: minimum number of low cycles after every step pulse before the next pulse.
- DUTY_MIN, 1: lowest shadow duty level, in 10% units.
- DUTY_MAX, 9: highest shadow duty level.
- DUTY_RST, 5: shadow level after reset. Matches the generator's 50% reset duty.
- RAMP_DIV, 1000: cycles between automatic steps in ramp mode.

Ports:
- clk  in  1  system clock, all state on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- btn_up  in  1  raw, asynchronous increase button
- btn_dn  in  1  raw, asynchronous decrease button
- mode_ramp  in  1  1 = auto-ramp, 0 = manual buttons
- inc_pulse  out  1  one-cycle step-up command to the generator
- dec_pulse  out  1  one-cycle step-down command to the generator
- duty_level  out  4  shadow duty level, DUTY_MIN..DUTY_MAX
- busy  out  1  high in PULSE and GAP states

Behaviour:
- Reset values while rst_n is low, all asynchronous: inc_pulse=0, dec_pulse=0, busy=0, duty_level=DUTY_RST, state=IDLE, pending=NONE, debounced levels=0, ramp counter=0, ramp direction=UP.
- Input path: each button passes through a 2-flop synchroniser, then a debouncer.
  - Debouncer counts consecutive cycles where the synchronised value differs from the debounced level.
  - On reaching DEB_CYCLES, the debounced level flips and the counter clears.
  - Any sample equal to the debounced level clears the counter.
- Edge detect: up_edge / dn_edge = debounced rising edge, one cycle wide. Releases generate nothing.
- Request formation each cycle:
  - Manual mode: req = INC on up_edge only, DEC on dn_edge only. Both in the same cycle cancel to NONE.
  - Ramp mode: button edges are ignored; req comes only from the ramp tick.
- FSM states: IDLE, PULSE, GAP.
  - IDLE, with req or pending != NONE: pending is served first, else req.
    - Step legal (INC with duty_level < DUTY_MAX, DEC with duty_level > DUTY_MIN): go to PULSE next cycle.
    - Step illegal: drop it and stay in IDLE.
  - PULSE (exactly 1 cycle):
    - The matching inc_pulse or dec_pulse is high.
    - duty_level updates by ±1 at the end of this cycle.
    - Next state is GAP.
  - GAP: lasts GAP_CYCLES cycles, then IDLE.
- Latency: a pulse is high exactly 1 cycle after the edge/tick cycle, when the FSM is IDLE.
- Pending buffer:
  - A request arriving in PULSE or GAP is stored in a one-deep pending slot if the slot is empty.
  - If the slot is full, the request is dropped.
  - A request opposite to the pending one clears the slot; they cancel.
- Saturation: duty_level never leaves [DUTY_MIN, DUTY_MAX]. No pulse is ever emitted past a limit.
- inc_pulse and dec_pulse are never high together. Consecutive pulses are always separated by at least GAP_CYCLES low cycles.
- Mode change:
  - mode_ramp is sampled every cycle.
  - A change clears pending and resets the ramp counter.
  - An in-flight PULSE/GAP always completes.
- Reset mid-operation: a pulse in progress is truncated and duty_level returns to DUTY_RST. The generator is assumed reset together with this block.

Optional Feature:
- Macro PWM_DUTY_CTRL_RAMP_EN.
- Defined:
  - Counter 0..RAMP_DIV-1; in ramp mode a tick fires when it wraps.
  - Tick produces a request in the ramp direction.
  - Direction flips to DOWN when duty_level==DUTY_MAX and to UP at DUTY_MIN, evaluated at tick time before the request forms. The sweep never stalls at a limit.
- Undefined:
  - Counter and direction logic are absent.
  - mode_ramp is ignored and the block behaves as in manual mode.

Decomposition:
- Package pwm_ctrl_pkg holds:
  - state enum (IDLE, PULSE, GAP)
  - request enum (NONE, INC, DEC)
  - DUTY_MIN, DUTY_MAX, DUTY_RST defaults
  - 4-bit duty-level type
- Sub-module pwm_btn_debounce: synchroniser, debouncer and rising-edge detect, parameterised by DEB_CYCLES. Instantiated twice.

Test Plan:
- Reset, then hold btn_up=1 for 20 cycles → one inc_pulse, high exactly 1 cycle. duty_level 5→6, busy high for 5 cycles.
- btn_up glitch of 10 cycles (< DEB_CYCLES=16) → no pulse; duty_level stays 5.
- Five clean up-presses spaced 40 cycles apart → four pulses, duty_level ends at 9. The fifth press produces no pulse.
- btn_up and btn_dn pressed in the same cycle → no pulse. A second up-press arriving during GAP is buffered and issued exactly GAP_CYCLES+1 cycles after the first pulse.
- With PWM_DUTY_CTRL_RAMP_EN, mode_ramp=1, RAMP_DIV=8 → pulses every 8 cycles; duty sequence 6,7,8,9,8,…,1,2. inc_pulse and dec_pulse are never simultaneous.
- Assert rst_n=0 during a PULSE cycle → inc_pulse drops immediately and duty_level=5. After release the FSM is in IDLE with pending empty.

Source files
------------

// File: rtl/pwm_duty_ctrl_pkg.sv
// Shared types and default duty limits for the PWM duty-step controller.
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
    typedef enum logic [1:0] {REQ_NONE, REQ_INC, REQ_DEC} req_t;

    localparam int DUTY_MIN_DEF = 1;
    localparam int DUTY_MAX_DEF = 9;
    localparam int DUTY_RST_DEF = 5;

    typedef logic [3:0] duty_t;

endpackage

// File: rtl/pwm_duty_ctrl_if.sv
// Button/mode inputs and step-command outputs of the duty controller.
interface pwm_duty_ctrl_if;

    logic                 btn_up;
    logic                 btn_dn;
    logic                 mode_ramp;
    logic                 inc_pulse;
    logic                 dec_pulse;
    pwm_ctrl_pkg::duty_t  duty_level;
    logic                 busy;

    modport master (
        output btn_up, btn_dn, mode_ramp,
        input  inc_pulse, dec_pulse, duty_level, busy
    );

    modport slave (
        input  btn_up, btn_dn, mode_ramp,
        output inc_pulse, dec_pulse, duty_level, busy
    );

endinterface

// File: rtl/pwm_duty_ctrl_debounce.sv
// Two-flop synchroniser, counting debouncer and one-cycle rising-edge detect.
module pwm_btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level;
    logic          level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync    <= {sync[0], btn};
            level_q <= level;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Turns debounced button presses (or ramp ticks) into spaced, range-limited step pulses.
// Optional auto-ramp mode is built only when PWM_DUTY_CTRL_RAMP_EN is defined.
module pwm_duty_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter int GAP_CYCLES = 4,
    parameter int DUTY_MIN   = DUTY_MIN_DEF,
    parameter int DUTY_MAX   = DUTY_MAX_DEF,
    parameter int DUTY_RST   = DUTY_RST_DEF,
    parameter int RAMP_DIV   = 1000
) (
    input logic            clk,
    input logic            rst_n,
    pwm_duty_ctrl_if.slave bus
);

    localparam int    GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam duty_t D_MIN = duty_t'(DUTY_MIN);
    localparam duty_t D_MAX = duty_t'(DUTY_MAX);
    localparam duty_t D_RST = duty_t'(DUTY_RST);

    logic    up_edge, dn_edge;
    logic    mode_chg, decide;
    req_t    req_man, req, pend, pend_eff, pend_nxt, svc;
    state_t  state;
    logic [GW-1:0] gap_cnt;
    duty_t   duty;
    logic    inc_q, dec_q, busy_q;

    pwm_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk(clk), .rst_n(rst_n), .btn(bus.btn_up), .rise(up_edge)
    );
    pwm_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
        .clk(clk), .rst_n(rst_n), .btn(bus.btn_dn), .rise(dn_edge)
    );

    always_comb begin
        req_man = REQ_NONE;
        if (up_edge && !dn_edge)      req_man = REQ_INC;
        else if (dn_edge && !up_edge) req_man = REQ_DEC;
    end

`ifdef PWM_DUTY_CTRL_RAMP_EN
    localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [RW-1:0] ramp_cnt;
    logic          mode_q, dir_dn, dir_dn_eff, tick;

    assign mode_chg = (bus.mode_ramp != mode_q);
    assign tick     = bus.mode_ramp && !mode_chg && (ramp_cnt == RW'(RAMP_DIV - 1));

    // Direction turns at the limits before the tick's request forms, so the sweep never stalls.
    always_comb begin
        dir_dn_eff = dir_dn;
        if (duty == D_MAX)      dir_dn_eff = 1'b1;
        else if (duty == D_MIN) dir_dn_eff = 1'b0;
    end

    always_comb begin
        req = req_man;
        if (bus.mode_ramp) req = tick ? (dir_dn_eff ? REQ_DEC : REQ_INC) : REQ_NONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= 1'b0;
            ramp_cnt <= '0;
            dir_dn   <= 1'b0;
        end else begin
            mode_q <= bus.mode_ramp;
            if (mode_chg || ramp_cnt == RW'(RAMP_DIV - 1)) ramp_cnt <= '0;
            else                                          ramp_cnt <= ramp_cnt + RW'(1);
            if (tick) dir_dn <= dir_dn_eff;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = bus.mode_ramp;
    assign mode_chg    = 1'b0;
    assign req         = req_man;
`endif

    function automatic logic step_ok(req_t r, duty_t d);
        return (r == REQ_INC && d < D_MAX) || (r == REQ_DEC && d > D_MIN);
    endfunction

    assign pend_eff = mode_chg ? REQ_NONE : pend;
    assign svc      = (pend_eff != REQ_NONE) ? pend_eff : req;
    // The last GAP cycle decides like IDLE so a buffered step issues GAP_CYCLES+1 after the previous one.
    assign decide   = (state == IDLE) || (state == GAP && gap_cnt == GW'(GAP_CYCLES - 1));

    always_comb begin
        pend_nxt = pend_eff;
        if (req != REQ_NONE) begin
            if (pend_eff == REQ_NONE)  pend_nxt = req;
            else if (req != pend_eff)  pend_nxt = REQ_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pend    <= REQ_NONE;
            gap_cnt <= '0;
            duty    <= D_RST;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            inc_q <= 1'b0;
            dec_q <= 1'b0;
            if (decide) begin
                pend <= REQ_NONE;
                if (step_ok(svc, duty)) begin
                    state  <= PULSE;
                    busy_q <= 1'b1;
                    inc_q  <= (svc == REQ_INC);
                    dec_q  <= (svc == REQ_DEC);
                end else begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            end else begin
                pend <= pend_nxt;
                if (state == PULSE) begin
                    state   <= GAP;
                    gap_cnt <= '0;
                    duty    <= inc_q ? duty + duty_t'(1) : duty - duty_t'(1);
                end else begin
                    gap_cnt <= gap_cnt + GW'(1);
                end
            end
        end
    end

    assign bus.inc_pulse  = inc_q;
    assign bus.dec_pulse  = dec_q;
    assign bus.busy       = busy_q;
    assign bus.duty_level = duty;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Bench for pwm_duty_ctrl: vector table, directed corner sequences, random run against a model.
module tb_pwm_duty_ctrl;

    localparam int DEB  = 16;
    localparam int GAPC = 4;
    localparam int DMIN = 1;
    localparam int DMAX = 9;
    localparam int DRST = 5;
`ifdef PWM_DUTY_CTRL_RAMP_EN
    localparam int RDIV = 8;
`else
    localparam int RDIV = 1000;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pwm_duty_ctrl_if bus();

    pwm_duty_ctrl #(
        .DEB_CYCLES(DEB), .GAP_CYCLES(GAPC), .DUTY_MIN(DMIN),
        .DUTY_MAX(DMAX), .DUTY_RST(DRST), .RAMP_DIV(RDIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int inc_cnt, dec_cnt;

    // Reference model state: edge index, last pulse edge, its direction, buffered step.
    int m_k, m_last, m_kind, m_pend, m_duty;
    int m_s0[2], m_s1[2], m_lvl[2], m_lvlq[2], m_run[2];
`ifdef PWM_DUTY_CTRL_RAMP_EN
    int m_rcnt, m_dir, m_mode_q;
`endif
    bit e_inc, e_dec, e_busy;
    int e_duty;

    typedef struct {
        bit up;
        bit dn;
        int hold;
        int exp_inc;
        int exp_dec;
        int exp_duty;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_k = 0; m_last = -1000; m_kind = 0; m_pend = 0; m_duty = DRST;
        for (int b = 0; b < 2; b++) begin
            m_s0[b] = 0; m_s1[b] = 0; m_lvl[b] = 0; m_lvlq[b] = 0; m_run[b] = 0;
        end
`ifdef PWM_DUTY_CTRL_RAMP_EN
        m_rcnt = 0; m_dir = 1; m_mode_q = 0;
`endif
        e_inc = 0; e_dec = 0; e_busy = 0; e_duty = DRST;
    endtask

    // One clock edge of the specified behaviour; leaves expected outputs for the following cycle.
    task automatic model_step();
        int rise[2];
        int raw[2];
        int req, pe, svc;
        bit chg;
        raw[0] = int'(bus.btn_up);
        raw[1] = int'(bus.btn_dn);
        for (int b = 0; b < 2; b++) begin
            rise[b] = (m_lvl[b] == 1 && m_lvlq[b] == 0) ? 1 : 0;
            m_lvlq[b] = m_lvl[b];
            if (m_s1[b] != m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_lvl[b] = m_s1[b];
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
            m_s1[b] = m_s0[b];
            m_s0[b] = raw[b];
        end
        req = (rise[0] == 1 && rise[1] == 0) ? 1 : (rise[1] == 1 && rise[0] == 0) ? -1 : 0;
        chg = 0;
`ifdef PWM_DUTY_CTRL_RAMP_EN
        begin
            bit tk;
            chg = (int'(bus.mode_ramp) != m_mode_q);
            tk  = bus.mode_ramp && !chg && (m_rcnt == RDIV - 1);
            if (tk) begin
                if (m_duty == DMAX)      m_dir = -1;
                else if (m_duty == DMIN) m_dir = 1;
            end
            if (bus.mode_ramp) req = tk ? m_dir : 0;
            m_rcnt   = (chg || m_rcnt == RDIV - 1) ? 0 : m_rcnt + 1;
            m_mode_q = int'(bus.mode_ramp);
        end
`endif
        pe = chg ? 0 : m_pend;
        if (m_k >= m_last + GAPC + 1) begin
            svc    = (pe != 0) ? pe : req;
            m_pend = 0;
            if ((svc == 1 && m_duty < DMAX) || (svc == -1 && m_duty > DMIN)) begin
                m_last = m_k;
                m_kind = svc;
            end
        end else if (req == 0)  m_pend = pe;
        else if (pe == 0)       m_pend = req;
        else if (req == -pe)    m_pend = 0;
        else                    m_pend = pe;
        if (m_k == m_last + 1) m_duty += m_kind;
        e_inc  = (m_k == m_last) && (m_kind == 1);
        e_dec  = (m_k == m_last) && (m_kind == -1);
        e_busy = (m_k - m_last) <= GAPC;
        e_duty = m_duty;
        m_k++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        n_tests++;
        if ({bus.inc_pulse, bus.dec_pulse, bus.busy, bus.duty_level} !==
            {e_inc, e_dec, e_busy, 4'(e_duty)}) begin
            n_fail++;
            $display("FAIL model edge %0d: got inc=%b dec=%b busy=%b duty=%0d, expected inc=%b dec=%b busy=%b duty=%0d",
                     m_k, bus.inc_pulse, bus.dec_pulse, bus.busy, bus.duty_level,
                     e_inc, e_dec, e_busy, e_duty);
        end
        if (bus.inc_pulse) inc_cnt++;
        if (bus.dec_pulse) dec_cnt++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
        bus.mode_ramp = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int first_inc, first_dec, busy_n;

        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
        bus.mode_ramp = 1'b0;

        // ---- reset state ----
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_inc",  int'(bus.inc_pulse), 0);
        check("rst_dec",  int'(bus.dec_pulse), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_duty", int'(bus.duty_level), DRST);
        rst_n = 1'b1;

        // ---- single clean press: latency, width, busy length ----
        inc_cnt = 0; dec_cnt = 0; first_inc = -1; busy_n = 0;
        bus.btn_up = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (bus.inc_pulse && first_inc < 0) first_inc = i;
            busy_n += int'(bus.busy);
            if (i == 20) bus.btn_up = 1'b0;
        end
        check("press_latency", first_inc, 19);
        check("press_inc_cnt", inc_cnt, 1);
        check("press_dec_cnt", dec_cnt, 0);
        check("press_busy_len", busy_n, GAPC + 1);
        check("press_duty", int'(bus.duty_level), 6);

        // ---- vector table from a fresh reset ----
        vecs[0] = '{1, 0, 20, 1, 0, 6};
        vecs[1] = '{1, 0, 10, 0, 0, 6};
        vecs[2] = '{0, 1, 20, 0, 1, 5};
        vecs[3] = '{1, 1, 20, 0, 0, 5};
        vecs[4] = '{1, 0, 15, 0, 0, 5};
        vecs[5] = '{1, 0, 16, 1, 0, 6};
        vecs[6] = '{1, 0, 20, 1, 0, 7};
        vecs[7] = '{1, 0, 20, 1, 0, 8};
        vecs[8] = '{1, 0, 20, 1, 0, 9};
        vecs[9] = '{1, 0, 20, 0, 0, 9};
        for (int j = 0; j < 8; j++) vecs[10 + j] = '{0, 1, 20, 0, 1, 8 - j};
        vecs[18] = '{0, 1, 20, 0, 0, 1};
        vecs[19] = '{1, 0, 20, 1, 0, 2};

        do_reset();
        for (int v = 0; v < 20; v++) begin
            inc_cnt = 0; dec_cnt = 0;
            bus.btn_up = vecs[v].up;
            bus.btn_dn = vecs[v].dn;
            for (int i = 0; i < vecs[v].hold; i++) tick();
            bus.btn_up = 1'b0;
            bus.btn_dn = 1'b0;
            for (int i = 0; i < 40; i++) tick();
            check($sformatf("vec%0d_inc", v), inc_cnt, vecs[v].exp_inc);
            check($sformatf("vec%0d_dec", v), dec_cnt, vecs[v].exp_dec);
            check($sformatf("vec%0d_duty", v), int'(bus.duty_level), vecs[v].exp_duty);
        end

        // ---- request arriving during GAP is buffered and issued GAP+1 after the first pulse ----
        first_inc = -1; first_dec = -1; inc_cnt = 0; dec_cnt = 0;
        bus.btn_dn = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (bus.inc_pulse && first_inc < 0) first_inc = i;
            if (bus.dec_pulse && first_dec < 0) first_dec = i;
            if (i == 3)  bus.btn_up = 1'b1;
            if (i == 20) bus.btn_dn = 1'b0;
            if (i == 23) bus.btn_up = 1'b0;
        end
        check("pend_dec_at", first_dec, 19);
        check("pend_inc_at", first_inc, 24);
        check("pend_spacing", first_inc - first_dec, GAPC + 1);
        check("pend_duty", int'(bus.duty_level), 2);

        // ---- reset asserted during a PULSE cycle ----
        first_dec = -1;
        bus.btn_dn = 1'b1;
        for (int i = 1; i <= 40 && first_dec < 0; i++) begin
            tick();
            if (bus.dec_pulse) first_dec = i;
            if (i == 1) bus.btn_up = 1'b1;
        end
        check("rstmid_pulse_seen", first_dec, 19);
        rst_n = 1'b0;
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
        #1;
        check("rstmid_dec", int'(bus.dec_pulse), 0);
        check("rstmid_busy", int'(bus.busy), 0);
        check("rstmid_duty", int'(bus.duty_level), DRST);
        model_reset();
        #2;
        rst_n = 1'b1;
        inc_cnt = 0; dec_cnt = 0;
        for (int i = 0; i < 60; i++) tick();
        check("rstmid_no_pulse", inc_cnt + dec_cnt, 0);

`ifdef PWM_DUTY_CTRL_RAMP_EN
        // ---- auto-ramp sweep ----
        begin
            int ramp_exp[14] = '{6, 7, 8, 9, 8, 7, 6, 5, 4, 3, 2, 1, 2, 3};
            int np, last;
            bit rec;
            np = 0; last = -1; rec = 0;
            do_reset();
            bus.mode_ramp = 1'b1;
            for (int i = 1; i <= 200 && np < 14; i++) begin
                tick();
                if (rec) begin
                    check($sformatf("ramp_duty%0d", np), int'(bus.duty_level), ramp_exp[np]);
                    np++;
                    rec = 0;
                end
                if (bus.inc_pulse || bus.dec_pulse) begin
                    if (last > 0) check("ramp_interval", i - last, RDIV);
                    last = i;
                    rec  = 1;
                end
            end
            check("ramp_count", np, 14);
            bus.mode_ramp = 1'b0;
        end
`endif

        // ---- randomized run against the model ----
        do_reset();
        for (int s = 0; s < 150; s++) begin
            int len;
            bus.btn_up = 1'($urandom_range(0, 1));
            bus.btn_dn = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 4) == 0) bus.mode_ramp = ~bus.mode_ramp;
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
